// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared constants for the RAM-backed FIFO controller and its dual-port RAM.
package ram_fifo_ctrl_pkg;

    localparam int FIFO_WIDTH = 8;
    localparam int FIFO_DEPTH = 64;

    // Level update selected per edge from the push/pop pair.
    typedef enum logic [1:0] {
        LVL_HOLD = 2'd0,
        LVL_INC  = 2'd1,
        LVL_DEC  = 2'd2
    } lvl_op_e;

    function automatic int depth_log(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/ram_fifo_ctrl_ptr.sv
// Wrapping RAM address pointer; rolls from DEPTH-1 to 0 by natural overflow.
module fifo_ptr #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    // Advance on each accepted transfer, clear on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + W'(1);
        end
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// First-word-fall-through FIFO controller driving an external dual-port RAM
// with asynchronous read. Level is the only full/empty discriminator, so the
// pointers need no extra wrap bit.
module ram_fifo_ctrl
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int WIDTH     = FIFO_WIDTH,
    parameter int DEPTH     = FIFO_DEPTH,
    parameter int AF_LEVEL  = 56,
    localparam int DEPTH_LOG = depth_log(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [WIDTH-1:0]     wr_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [WIDTH-1:0]     rd_data,
    output logic [DEPTH_LOG:0]   level,
    output logic                 almost_full,
    output logic                 ram_we_n,
    output logic [DEPTH_LOG-1:0] ram_addr_wr,
    output logic [WIDTH-1:0]     ram_data_wr,
    output logic [DEPTH_LOG-1:0] ram_addr_rd,
    input  logic [WIDTH-1:0]     ram_data_rd
);

    localparam logic [DEPTH_LOG:0] LEVEL_FULL = (DEPTH_LOG+1)'(DEPTH);
    localparam logic [DEPTH_LOG:0] LEVEL_AF   = (DEPTH_LOG+1)'(AF_LEVEL);

    logic                 push;
    logic                 pop;
    logic [DEPTH_LOG-1:0] wr_ptr;
    logic [DEPTH_LOG-1:0] rd_ptr;
    lvl_op_e              lvl_op;

    // Handshakes are gated by reset so nothing is written or consumed in a
    // reset cycle. Full refuses pushes even when a pop frees a slot this edge.
    assign wr_ready = ~rst & (level != LEVEL_FULL);
    assign rd_valid = ~rst & (level != '0);
    assign push     = wr_valid & wr_ready;
    assign pop      = rd_valid & rd_ready;

    // RAM port drive; read data falls straight through from the async port.
    assign ram_we_n    = ~push;
    assign ram_addr_wr = wr_ptr;
    assign ram_data_wr = wr_data;
    assign ram_addr_rd = rd_ptr;
    assign rd_data     = ram_data_rd;

    assign almost_full = (level >= LEVEL_AF);

    fifo_ptr #(.W(DEPTH_LOG)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (push),
        .ptr (wr_ptr)
    );

    fifo_ptr #(.W(DEPTH_LOG)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (pop),
        .ptr (rd_ptr)
    );

    // Select the level update; simultaneous push and pop leaves it unchanged.
    always_comb begin
        lvl_op = LVL_HOLD;
        if (push && !pop) begin
            lvl_op = LVL_INC;
        end else if (pop && !push) begin
            lvl_op = LVL_DEC;
        end
    end

    // Fill level register.
    always_ff @(posedge clk) begin
        if (rst) begin
            level <= '0;
        end else begin
            case (lvl_op)
                LVL_INC: level <= level + (DEPTH_LOG+1)'(1);
                LVL_DEC: level <= level - (DEPTH_LOG+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with a behavioural async-read dual-port RAM.
module tb_ram_fifo_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 64;
    localparam int DL    = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_valid;
    logic             wr_ready;
    logic [WIDTH-1:0] wr_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH-1:0] rd_data;
    logic [DL:0]      level;
    logic             almost_full;
    logic             ram_we_n;
    logic [DL-1:0]    ram_addr_wr;
    logic [WIDTH-1:0] ram_data_wr;
    logic [DL-1:0]    ram_addr_rd;
    logic [WIDTH-1:0] ram_data_rd;

    logic [WIDTH-1:0] mem [DEPTH];

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] sb[$];
    int               m_level = 0;
    int               m_wptr  = 0;
    int               m_rptr  = 0;
    bit               done    = 0;

    always #5 clk = ~clk;

    ram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(56)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .level       (level),
        .almost_full (almost_full),
        .ram_we_n    (ram_we_n),
        .ram_addr_wr (ram_addr_wr),
        .ram_data_wr (ram_data_wr),
        .ram_addr_rd (ram_addr_rd),
        .ram_data_rd (ram_data_rd)
    );

    // Behavioural RAM: synchronous active-low write, asynchronous read.
    always @(posedge clk) begin
        if (!ram_we_n) mem[ram_addr_wr] <= ram_data_wr;
    end
    assign ram_data_rd = mem[ram_addr_rd];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: on every edge decide what the FIFO must accept and
    // push the accepted word into the scoreboard.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                sb.delete();
                m_level = 0;
                m_wptr  = 0;
                m_rptr  = 0;
            end else begin
                bit mp, mq;
                mp = wr_valid && (m_level != DEPTH);
                mq = rd_ready && (m_level != 0);
                if (mp) begin
                    sb.push_back(wr_data);
                    m_wptr = (m_wptr + 1) % DEPTH;
                end
                if (mq) begin
                    void'(sb.pop_front());
                    m_rptr = (m_rptr + 1) % DEPTH;
                end
                if (mp && !mq) m_level++;
                if (mq && !mp) m_level--;
            end
        end
    end

    // Monitor: away from the active edge, compare flags, RAM drive and any
    // word being taken against the model and the scoreboard front.
    initial begin
        forever begin
            @(negedge clk);
            if (done) break;
            check("level",       int'(level),       m_level);
            check("wr_ready",    int'(wr_ready),    int'(!rst && m_level != DEPTH));
            check("rd_valid",    int'(rd_valid),    int'(!rst && m_level != 0));
            check("almost_full", int'(almost_full), int'(m_level >= 56));
            check("ram_we_n",    int'(ram_we_n),    int'(!(!rst && wr_valid && m_level != DEPTH)));
            check("ram_addr_wr", int'(ram_addr_wr), m_wptr);
            check("ram_addr_rd", int'(ram_addr_rd), m_rptr);
            if (rd_valid && rd_ready && sb.size() > 0)
                check("rd_data", int'(rd_data), int'(sb[0]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
        #1;
        // Reset held two cycles.
        step();
        check("rst_wr_ready", int'(wr_ready), 0);
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_we_n",     int'(ram_we_n), 1);
        step();
        check("rst_level",    int'(level), 0);
        rst = 1'b0;
        #1;
        check("post_rst_wr_ready", int'(wr_ready), 1);

        // Fill 0x00..0x3F with no reads.
        for (int i = 0; i < DEPTH; i++) begin
            wr_valid = 1'b1; wr_data = WIDTH'(i);
            step();
            if (i == 54) check("af_below", int'(almost_full), 0);
            if (i == 55) check("af_at_56", int'(almost_full), 1);
        end
        check("full_level",    int'(level), 64);
        check("full_wr_ready", int'(wr_ready), 0);
        // Refused pushes while full.
        wr_data = 8'hEE;
        step();
        // Push and pop together at full: only the pop is taken.
        rd_ready = 1'b1;
        #1;
        check("full_pop_we_n", int'(ram_we_n), 1);
        step();
        check("full_pop_level", int'(level), 63);
        wr_valid = 1'b0;
        // Drain the rest.
        for (int i = 0; i < 65; i++) step();
        check("drained_rd_valid", int'(rd_valid), 0);
        rd_ready = 1'b0;

        // Single word into empty: no bypass in the push cycle.
        wr_valid = 1'b1; wr_data = 8'hA5;
        #1;
        check("empty_no_bypass", int'(rd_valid), 0);
        step();
        wr_valid = 1'b0;
        check("single_rd_valid", int'(rd_valid), 1);
        check("single_rd_data",  int'(rd_data), 8'hA5);
        rd_ready = 1'b1;
        step();
        check("single_level", int'(level), 0);

        // Streaming with wrap-around.
        for (int i = 0; i < 200; i++) begin
            wr_valid = 1'b1; wr_data = WIDTH'(i + 3);
            step();
            if (i == 100) check("stream_level", int'(level), 1);
        end
        wr_valid = 1'b0;
        step();
        rd_ready = 1'b0;

        // Reset mid-stream at level 10 with a push offered.
        for (int i = 0; i < 10; i++) begin
            wr_valid = 1'b1; wr_data = WIDTH'(8'h40 + i);
            step();
        end
        check("pre_rst_level", int'(level), 10);
        rst = 1'b1; wr_data = 8'h77;
        #1;
        check("rst_mid_we_n", int'(ram_we_n), 1);
        step();
        rst = 1'b0; wr_valid = 1'b0;
        #1;
        check("rst_mid_level",    int'(level), 0);
        check("rst_mid_rd_valid", int'(rd_valid), 0);
        step();
        step();

        done = 1;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
